// File: rtl/regfile_wb_scheduler_if.sv
// Writeback requesters, register-file write port and hazard-check bundle for the writeback scheduler.
interface regfile_wb_scheduler_if #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
);
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   rf_we;
    logic [ADDR_W-1:0]      rf_waddr;
    logic [DATA_W-1:0]      rf_wdata;
    logic                   issue_valid;
    logic [ADDR_W-1:0]      issue_addr;
    logic                   issue_ready;
    logic [ADDR_W-1:0]      chk_addr1;
    logic [ADDR_W-1:0]      chk_addr2;
    logic                   chk_busy1;
    logic                   chk_busy2;
    logic [(1<<ADDR_W)-1:0] pending_vec;
    logic                   err_wb_unres;

    modport master (
        output req_valid, req_addr, req_data, issue_valid, issue_addr, chk_addr1, chk_addr2,
        input  req_ready, rf_we, rf_waddr, rf_wdata, issue_ready, chk_busy1, chk_busy2,
               pending_vec, err_wb_unres
    );

    modport slave (
        input  req_valid, req_addr, req_data, issue_valid, issue_addr, chk_addr1, chk_addr2,
        output req_ready, rf_we, rf_waddr, rf_wdata, issue_ready, chk_busy1, chk_busy2,
               pending_vec, err_wb_unres
    );
endinterface

// File: rtl/regfile_wb_scheduler.sv
// Round-robin share of the register-file write port plus per-register pending scoreboard.
// Latency: accepted writeback appears on rf_we/rf_waddr/rf_wdata one cycle after the accept edge.
// Backpressure: one-hot req_ready from combinational arbiter; issue_ready drops on a pending register.
module regfile_wb_scheduler #(
    parameter int NREQ   = 2,
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    regfile_wb_scheduler_if.slave bus
);
    localparam int NREG = 1 << ADDR_W;
    localparam int PW   = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PW-1:0]     rr_ptr;
    logic [PW-1:0]     gnt_idx;
    logic [NREQ-1:0]   grant;
    logic              gnt_any;
    logic              accept;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [NREG-1:0]   pending;
    logic [NREG-1:0]   set_vec;
    logic [NREG-1:0]   clr_vec;
    logic              issue_fire;
    logic              rf_we_q;
    logic [ADDR_W-1:0] rf_waddr_q;
    logic [DATA_W-1:0] rf_wdata_q;
    logic              err_q;

    // First valid requester at or above the rotating pointer wins.
    always_comb begin
        grant   = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_any && bus.req_valid[(int'(rr_ptr) + k) % NREQ]) begin
                grant[(int'(rr_ptr) + k) % NREQ] = 1'b1;
                gnt_idx = PW'((int'(rr_ptr) + k) % NREQ);
                gnt_any = 1'b1;
            end
        end
    end

    // Ready is forced low while reset is held so no requester sees a phantom accept.
    assign bus.req_ready = rst_n ? grant : '0;
    assign accept        = |(bus.req_valid & bus.req_ready);
    assign sel_addr      = bus.req_addr[gnt_idx*ADDR_W +: ADDR_W];
    assign sel_data      = bus.req_data[gnt_idx*DATA_W +: DATA_W];

    assign bus.issue_ready = !pending[bus.issue_addr];
    assign issue_fire      = bus.issue_valid && bus.issue_ready;

    // Clear lands one edge after the write cycle; a same-edge reservation wins.
    assign set_vec = issue_fire ? (NREG'(1) << bus.issue_addr) : '0;
    assign clr_vec = rf_we_q ? (NREG'(1) << rf_waddr_q) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr     <= '0;
            rf_we_q    <= 1'b0;
            rf_waddr_q <= '0;
            rf_wdata_q <= '0;
            pending    <= '0;
            err_q      <= 1'b0;
        end else begin
            rf_we_q <= accept;
            pending <= (pending & ~clr_vec) | set_vec;
            if (accept) begin
                rr_ptr     <= (gnt_idx == PW'(NREQ-1)) ? '0 : gnt_idx + 1'b1;
                rf_waddr_q <= sel_addr;
                rf_wdata_q <= sel_data;
                if (!pending[sel_addr])
                    err_q <= 1'b1;
            end
        end
    end

    assign bus.rf_we        = rf_we_q;
    assign bus.rf_waddr     = rf_waddr_q;
    assign bus.rf_wdata     = rf_wdata_q;
    assign bus.chk_busy1    = pending[bus.chk_addr1];
    assign bus.chk_busy2    = pending[bus.chk_addr2];
    assign bus.pending_vec  = pending;
    assign bus.err_wb_unres = err_q;
endmodule
